// File: rtl/switch_debounce.sv
// Slide-switch conditioner: per-bit synchroniser and debounce counter, plus a
// frame-aligned copy of the debounced value that only updates at vsync assertion.
module switch_debounce #(
  parameter int WIDTH            = 3,
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 1_000_000,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             vsync,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic [WIDTH-1:0] sw_frame
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sw_sync;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic             changed_q;
  logic             vs_hist_q;
  logic             vs_act;

  assign sw_sync = sync_q[SYNC_STAGES-1];
  assign vs_act  = VSYNC_ACTIVE_LOW ? ~vsync : vsync;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sw_sync[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sw_sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // Captures the value held before any acceptance on this same edge.
    frame_d = (vs_act && !vs_hist_q) ? stable_q : frame_q;
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours (the synchroniser relies on it).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      stable_q  <= '0;
      frame_q   <= '0;
      changed_q <= 1'b0;
      vs_hist_q <= 1'b0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      stable_q  <= stable_d;
      frame_q   <= frame_d;
      changed_q <= (stable_d != stable_q);
      vs_hist_q <= vs_act;
    end
  end

  assign sw_stable  = stable_q;
  assign sw_changed = changed_q;
  assign sw_frame   = frame_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios plus random stimulus, with a
// window-based reference model feeding a per-cycle scoreboard.
module tb_switch_debounce;

  localparam int W  = 3;
  localparam int SS = 2;
  localparam int D  = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic         vsync;
  logic [W-1:0] sw_stable;
  logic         sw_changed;
  logic [W-1:0] sw_frame;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit vs_manual = 1'b0;

  switch_debounce #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .VSYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .vsync(vsync),
    .sw_stable(sw_stable), .sw_changed(sw_changed), .sw_frame(sw_frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a bit flips once its synchronised value has differed from
  // the stable value for each of the last D clocks (a sliding window).
  typedef struct packed {
    logic [W-1:0] stable;
    logic         changed;
    logic [W-1:0] frame;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] pipe_m[$];
  logic [W-1:0] hist_m[$];
  logic [W-1:0] m_stable  = '0;
  logic [W-1:0] m_frame   = '0;
  logic         m_changed = 1'b0;
  logic         m_act_prev = 1'b0;

  always @(posedge clk) begin : model
    logic [W-1:0] sync_pre;
    logic [W-1:0] nxt;
    logic         act;
    logic         all_diff;
    exp_t         e;
    if (rst) begin
      pipe_m.delete();
      for (int s = 0; s < SS; s++) pipe_m.push_back('0);
      hist_m.delete();
      m_stable   = '0;
      m_frame    = '0;
      m_changed  = 1'b0;
      m_act_prev = 1'b0;
    end else begin
      sync_pre = pipe_m.pop_front();
      pipe_m.push_back(sw_raw);
      hist_m.push_back(sync_pre);
      if (hist_m.size() > D) void'(hist_m.pop_front());
      nxt = m_stable;
      if (hist_m.size() == D) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          foreach (hist_m[k]) if (hist_m[k][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) nxt[i] = ~m_stable[i];
        end
      end
      act = ~vsync;
      if (act && !m_act_prev) m_frame = m_stable;
      m_act_prev = act;
      m_changed  = (nxt != m_stable);
      m_stable   = nxt;
    end
    e.stable  = m_stable;
    e.changed = m_changed;
    e.frame   = m_frame;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_stable",  32'(sw_stable),  32'(e.stable));
      check("sb_changed", 32'(sw_changed), 32'(e.changed));
      check("sb_frame",   32'(sw_frame),   32'(e.frame));
    end
  end

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!vs_manual) vsync = ((cyc % 37) < 3) ? 1'b0 : 1'b1;
  endtask

  task automatic do_reset(input int n);
    sw_raw = '0;
    rst    = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin : stim
    logic [W-1:0] v;
    bit           seen;
    rst    = 1'b1;
    sw_raw = 3'b111;
    vsync  = 1'b1;

    // Reset holds everything at zero even with all switches on.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_stable",  32'(sw_stable),  32'd0);
      check("rst_frame",   32'(sw_frame),   32'd0);
      check("rst_changed", 32'(sw_changed), 32'd0);
    end
    do_reset(1);

    // Clean step: accepted at edge SS+D, one pulse, frame follows at next vsync.
    tick();
    sw_raw = 3'b101;
    repeat (D + SS - 1) tick();
    check("step_early", 32'(sw_stable), 32'd0);
    tick();
    check("step_stable",  32'(sw_stable),  32'b101);
    check("step_changed", 32'(sw_changed), 32'd1);
    check("step_frame_held", 32'(sw_frame), 32'd0);
    tick();
    check("step_pulse_end", 32'(sw_changed), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (sw_frame == 3'b101) seen = 1'b1;
    end
    check("step_frame_arrives", 32'(seen), 32'd1);

    // Bounce on bit 0 keeps clearing the count.
    do_reset(2);
    tick();
    for (int k = 0; k < 20; k++) begin
      sw_raw[0] = ~sw_raw[0];
      repeat (5) tick();
    end
    check("bounce_hold", 32'(sw_stable[0]), 32'd0);
    sw_raw[0] = 1'b1;
    repeat (D + SS - 1) tick();
    check("bounce_early", 32'(sw_stable[0]), 32'd0);
    tick();
    check("bounce_accept", 32'(sw_stable[0]), 32'd1);

    // Glitch one clock short of the debounce window never gets through.
    do_reset(2);
    tick();
    seen = 1'b0;
    sw_raw[1] = 1'b1;
    for (int k = 0; k < 15; k++) begin tick(); seen |= sw_changed; end
    sw_raw[1] = 1'b0;
    for (int k = 0; k < 40; k++) begin tick(); seen |= sw_changed; end
    check("glitch_stable", 32'(sw_stable), 32'd0);
    check("glitch_no_pulse", 32'(seen), 32'd0);

    // Acceptance on the same edge as vsync assertion: frame gets the old value.
    vs_manual = 1'b1;
    vsync     = 1'b1;
    do_reset(2);
    tick();
    sw_raw = 3'b001;
    repeat (D + SS - 1) tick();
    vsync = 1'b0;
    tick();
    check("simul_stable", 32'(sw_stable), 32'b001);
    check("simul_frame_old", 32'(sw_frame), 32'd0);
    repeat (3) tick();
    vsync = 1'b1;
    repeat (3) tick();
    check("simul_frame_hold", 32'(sw_frame), 32'd0);
    vsync = 1'b0;
    tick();
    check("simul_frame_new", 32'(sw_frame), 32'b001);
    vsync = 1'b1;
    vs_manual = 1'b0;

    // Reset mid-count discards the pending change; full latency after release.
    do_reset(2);
    tick();
    sw_raw = 3'b011;
    repeat (10) tick();
    rst = 1'b1;
    repeat (2) tick();
    check("midrst_stable", 32'(sw_stable), 32'd0);
    rst = 1'b0;
    repeat (D + SS - 1) tick();
    check("midrst_early", 32'(sw_stable), 32'd0);
    tick();
    check("midrst_accept", 32'(sw_stable), 32'b011);

    // Random phase: hold lengths straddle the debounce window.
    for (int seg = 0; seg < 80; seg++) begin
      v = W'($urandom);
      sw_raw = v;
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 30)) tick();
    end

    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
